// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and redirect controller.
// Detects load-use and branch-operand hazards, sequences taken jumps
// against instruction-memory readiness and freezes the pipe while data
// memory is busy. Optional performance counters are built only when the
// macro HAZARD_CTRL_PERF_EN is defined; otherwise stall_cnt/flush_cnt read 0.
//
// state | meaning
// RUN   | normal flow; hazards and jumps evaluated every cycle
// DWAIT | data memory busy; whole pipe frozen until dmem_ready
// RPEND | taken jump waiting for imem_ready; target held in tgt_q
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_is_branch,
  input  logic        id_jmp_sig,
  input  logic [31:0] id_jmp_addr,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipe_en,
  output logic        redirect,
  output logic [31:0] redir_addr,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    RPEND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic ex_nz, mem_nz;
  logic load_use, br_haz, hazard, taken;

  // Register 0 is hardwired, so a zero destination never matches.
  assign ex_nz  = (ex_rd != 5'd0);
  assign mem_nz = (mem_rd != 5'd0);
  assign rs_ex  = id_use_rs & (id_rs == ex_rd);
  assign rt_ex  = id_use_rt & (id_rt == ex_rd);
  assign rs_mem = id_use_rs & (id_rs == mem_rd);
  assign rt_mem = id_use_rt & (id_rt == mem_rd);

  assign load_use = id_valid & ex_mem_read & ex_nz & (rs_ex | rt_ex);
  // Branches resolve in ID, so any in-flight EX result or MEM load blocks them.
  assign br_haz   = id_valid & id_is_branch &
                    ((ex_reg_write & ex_nz & (rs_ex | rt_ex)) |
                     (mem_mem_read & mem_nz & (rs_mem | rt_mem)));
  assign hazard   = load_use | br_haz;
  assign taken    = id_jmp_sig & id_valid & ~hazard;

  assign state = state_q;

  // Next-state and Mealy pipeline controls; reset forces plain RUN defaults.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    pipe_en      = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    redirect     = 1'b0;
    redir_addr   = 32'd0;
    state_d      = state_q;
    tgt_d        = tgt_q;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (!dmem_ready) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            pipe_en  = 1'b0;
            state_d  = DWAIT;
          end else if (hazard) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (taken && imem_ready) begin
            redirect    = 1'b1;
            redir_addr  = id_jmp_addr;
            if_id_flush = 1'b1;
          end else if (taken) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            tgt_d       = id_jmp_addr;
            state_d     = RPEND;
          end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        DWAIT: begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          pipe_en  = 1'b0;
          if (dmem_ready) state_d = RUN;
        end
        RPEND: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          redir_addr  = tgt_q;
          pipe_en     = dmem_ready;
          if (imem_ready) begin
            redirect = 1'b1;
            pc_en    = 1'b1;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and latched jump target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [15:0] stall_q, stall_d, flush_q, flush_d;

  // Saturating increments for stall and flush cycles.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    if (if_id_flush && flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, branch hazards, jump
// redirect with imem stall, data wait, zero register and reset mid-RPEND.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs, id_use_rt, id_is_branch, id_jmp_sig;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic [31:0] id_jmp_addr;
  logic        ex_reg_write, ex_mem_read, mem_mem_read, imem_ready, dmem_ready;
  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en, redirect;
  logic [31:0] redir_addr;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_jmp_sig(id_jmp_sig), .id_jmp_addr(id_jmp_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_en(pipe_en),
    .redirect(redirect), .redir_addr(redir_addr), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_branch = 1'b0;
    id_jmp_sig = 1'b0; id_jmp_addr = 32'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b0; mem_rd = 5'd0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    settle();
    chk("rst_state", 32'(state), 0);
    chk("rst_pc_en", 32'(pc_en), 1);
    chk("rst_pipe_en", 32'(pipe_en), 1);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // idle RUN
    settle();
    chk("idle_pc_en", 32'(pc_en), 1);
    chk("idle_bubble", 32'(id_ex_bubble), 0);
    chk("idle_redir_addr", redir_addr, 0);

    // load-use on rs
    id_rs = 5'd5; id_use_rs = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    settle();
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_if_id_en", 32'(if_id_en), 0);
    chk("lu_bubble", 32'(id_ex_bubble), 1);
    chk("lu_pipe_en", 32'(pipe_en), 1);
    tick();
    ex_mem_read = 1'b0;
    settle();
    chk("lu_clear_pc_en", 32'(pc_en), 1);
    chk("lu_clear_bubble", 32'(id_ex_bubble), 0);
    tick();

    // rt matches a load but rt is not read -> no hazard
    idle(); id_rt = 5'd7; ex_rd = 5'd7; ex_mem_read = 1'b1;
    settle();
    chk("rt_unused_pc_en", 32'(pc_en), 1);
    tick();

    // zero register never stalls
    idle(); id_rs = 5'd0; id_use_rs = 1'b1; ex_rd = 5'd0; ex_mem_read = 1'b1;
    settle();
    chk("zero_pc_en", 32'(pc_en), 1);
    chk("zero_bubble", 32'(id_ex_bubble), 0);
    tick();

    // non-branch ALU dependency is forwarded, no stall
    idle(); id_rt = 5'd3; id_use_rt = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3;
    settle();
    chk("alu_fwd_pc_en", 32'(pc_en), 1);
    tick();

    // branch hazard blocks a taken jump, then redirect once clear
    idle(); id_is_branch = 1'b1; id_rt = 5'd3; id_use_rt = 1'b1;
    ex_reg_write = 1'b1; ex_rd = 5'd3; id_jmp_sig = 1'b1; id_jmp_addr = 32'h0000_1000;
    settle();
    chk("br_haz_redirect", 32'(redirect), 0);
    chk("br_haz_bubble", 32'(id_ex_bubble), 1);
    chk("br_haz_redir_addr", redir_addr, 0);
    tick();
    ex_reg_write = 1'b0;
    settle();
    chk("br_clr_redirect", 32'(redirect), 1);
    chk("br_clr_redir_addr", redir_addr, 32'h0000_1000);
    chk("br_clr_flush", 32'(if_id_flush), 1);
    chk("br_clr_pc_en", 32'(pc_en), 1);
    tick();

    // branch blocked by a load in MEM
    idle(); id_is_branch = 1'b1; id_rs = 5'd9; id_use_rs = 1'b1;
    mem_mem_read = 1'b1; mem_rd = 5'd9;
    settle();
    chk("br_mem_bubble", 32'(id_ex_bubble), 1);
    tick();

    // invalid ID slot never jumps
    idle(); id_valid = 1'b0; id_jmp_sig = 1'b1; id_jmp_addr = 32'h0000_2000;
    settle();
    chk("invalid_redirect", 32'(redirect), 0);
    tick();

    // plain imem stall without a jump
    idle(); imem_ready = 1'b0;
    settle();
    chk("imem_stall_pc_en", 32'(pc_en), 0);
    chk("imem_stall_flush", 32'(if_id_flush), 1);
    chk("imem_stall_state", 32'(state), 0);
    tick();

    // taken jump with imem stalled: RPEND for 3 cycles, then RUN
    idle(); id_jmp_sig = 1'b1; id_jmp_addr = 32'h0040_0020; imem_ready = 1'b0;
    settle();
    chk("rp0_state", 32'(state), 0);
    chk("rp0_pc_en", 32'(pc_en), 0);
    chk("rp0_flush", 32'(if_id_flush), 1);
    chk("rp0_redirect", 32'(redirect), 0);
    tick();
    idle(); imem_ready = 1'b0;
    id_rs = 5'd4; id_use_rs = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4;
    id_jmp_sig = 1'b1; id_jmp_addr = 32'h0000_3000;
    settle();
    chk("rp1_state", 32'(state), 2);
    chk("rp1_pc_en", 32'(pc_en), 0);
    chk("rp1_bubble", 32'(id_ex_bubble), 0);
    chk("rp1_redir_addr", redir_addr, 32'h0040_0020);
    chk("rp1_redirect", 32'(redirect), 0);
    tick();
    idle(); imem_ready = 1'b0; dmem_ready = 1'b0;
    settle();
    chk("rp2_state", 32'(state), 2);
    chk("rp2_pipe_en", 32'(pipe_en), 0);
    tick();
    idle();
    settle();
    chk("rp3_state", 32'(state), 2);
    chk("rp3_redirect", 32'(redirect), 1);
    chk("rp3_pc_en", 32'(pc_en), 1);
    chk("rp3_redir_addr", redir_addr, 32'h0040_0020);
    tick();
    settle();
    chk("rp_done_state", 32'(state), 0);
    chk("rp_done_redirect", 32'(redirect), 0);
    chk("rp_done_redir_addr", redir_addr, 0);
    tick();

    // data wait: dmem low for 2 cycles, pipe frozen 3 cycles
    idle(); dmem_ready = 1'b0;
    id_rs = 5'd6; id_use_rs = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd6;
    settle();
    chk("dw0_state", 32'(state), 0);
    chk("dw0_pipe_en", 32'(pipe_en), 0);
    chk("dw0_pc_en", 32'(pc_en), 0);
    chk("dw0_bubble", 32'(id_ex_bubble), 0);
    tick();
    idle(); dmem_ready = 1'b0; id_jmp_sig = 1'b1; id_jmp_addr = 32'h0000_4000;
    settle();
    chk("dw1_state", 32'(state), 1);
    chk("dw1_pipe_en", 32'(pipe_en), 0);
    chk("dw1_redirect", 32'(redirect), 0);
    tick();
    idle();
    settle();
    chk("dw2_state", 32'(state), 1);
    chk("dw2_pipe_en", 32'(pipe_en), 0);
    chk("dw2_pc_en", 32'(pc_en), 0);
    tick();
    settle();
    chk("dw3_state", 32'(state), 0);
    chk("dw3_pipe_en", 32'(pipe_en), 1);
    tick();

    // reset during RPEND discards the pending redirect
    idle(); id_jmp_sig = 1'b1; id_jmp_addr = 32'hDEAD_0000; imem_ready = 1'b0;
    tick();
    idle(); imem_ready = 1'b0;
    settle();
    chk("rr_pre_state", 32'(state), 2);
    imem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rr_state", 32'(state), 0);
    chk("rr_redirect", 32'(redirect), 0);
    chk("rr_pc_en", 32'(pc_en), 1);
    chk("rr_flush", 32'(if_id_flush), 0);
    chk("rr_redir_addr", redir_addr, 0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rr_after_state", 32'(state), 0);
    chk("rr_after_redirect", 32'(redirect), 0);
    chk("rr_after_stall_cnt", 32'(stall_cnt), 0);
    chk("rr_after_flush_cnt", 32'(flush_cnt), 0);
    tick();

    // two flushed stall cycles
    idle(); imem_ready = 1'b0;
    tick(); tick();
    idle();
    settle();
`ifdef HAZARD_CTRL_PERF_EN
    chk("perf_stall_cnt", 32'(stall_cnt), 2);
    chk("perf_flush_cnt", 32'(flush_cnt), 2);
`else
    chk("perf_stall_cnt", 32'(stall_cnt), 0);
    chk("perf_flush_cnt", 32'(flush_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have these ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  ID source register numbers
- id_use_rs, id_use_rt  in  1 each  ID reads rs / rt
- id_is_branch  in  1  ID is beq/bne/jr (operands consumed in ID)
- id_jmp_sig, id_jmp_addr  in  1 / 32  ID taken-jump flag and target
- ex_reg_write, ex_mem_read, ex_rd  in  1/1/5  EX stage writeback info
- mem_mem_read, mem_rd  in  1/5  MEM stage load info
- imem_ready, dmem_ready  in  1 each  memory ready
- pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en  out  1 each  pipeline controls
- redirect, redir_addr  out  1 / 32  PC load and target
- state  out  2  FSM state (RUN=0, DWAIT=1, RPEND=2)
- stall_cnt, flush_cnt  out  16 each  performance counters

Function
REQ-002 SHALL define load_use = id_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-003 SHALL define br_haz = id_valid & id_is_branch & match against (ex_reg_write & ex_rd!=0) or (mem_mem_read & mem_rd!=0); hazard = load_use | br_haz.
REQ-004 SHALL gate taken = id_jmp_sig & id_valid & !hazard.
REQ-005 Outputs SHALL be combinational from state and inputs (Mealy). Defaults: pc_en=1, if_id_en=1, pipe_en=1, all others 0.
REQ-006 RUN, priority high to low:
- !dmem_ready: pc_en=if_id_en=pipe_en=0; next DWAIT.
- hazard: pc_en=if_id_en=0, id_ex_bubble=1; stay in RUN.
- taken & imem_ready: redirect=1, redir_addr=id_jmp_addr, if_id_flush=1.
- taken & !imem_ready: pc_en=0, if_id_flush=1, latch id_jmp_addr; next RPEND.
- !imem_ready: pc_en=0, if_id_flush=1.
REQ-007 DWAIT: pc_en=if_id_en=pipe_en=0 every cycle, including the cycle dmem_ready=1. Next state is RUN when dmem_ready=1. Hazard and jump evaluation resumes one cycle after dmem_ready rises.
REQ-008 RPEND: pc_en=0, if_id_flush=1, redir_addr=latched target, pipe_en=dmem_ready. When imem_ready=1: redirect=1, pc_en=1; next RUN.
REQ-009 id_jmp_sig and all hazard inputs SHALL be ignored in DWAIT and RPEND.
REQ-010 redir_addr SHALL be 0 when redirect=0 in RUN.
REQ-011 Register 0 SHALL never create a hazard.

Reset
REQ-012 rst_n=0 SHALL immediately force state=RUN, latched target=0 and counters=0, from any state including mid-RPEND. A pending redirect is discarded.
REQ-013 While rst_n=0, outputs SHALL take their RUN defaults, with redirect=0.

Configuration
REQ-014 With macro HAZARD_CTRL_PERF_EN defined:
- stall_cnt increments on each cycle with pc_en=0.
- flush_cnt increments on each cycle with if_id_flush=1.
- Both saturate at 16'hFFFF.
REQ-015 Without HAZARD_CTRL_PERF_EN, stall_cnt and flush_cnt SHALL remain as ports, tied to 0, with no counter flops.

Verification
REQ-016 Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_use_rs=1, then next cycle ex_mem_read=0 -> one cycle of pc_en=0 and id_ex_bubble=1, then normal.
REQ-017 Branch hazard: id_is_branch=1, id_rt=3, ex_reg_write=1, ex_rd=3, id_jmp_sig=1 -> no redirect that cycle; redirect=1 the cycle after the hazard clears.
REQ-018 Redirect stall: taken jump with id_jmp_addr=0x00400020 and imem_ready=0 for 3 cycles -> state=RPEND for 3 cycles, then redirect=1 with redir_addr=0x00400020, then RUN.
REQ-019 Data wait: dmem_ready=0 for 2 cycles -> state=DWAIT; pipe_en=0 for 3 cycles total; RUN on the 4th cycle.
REQ-020 Zero register and reset:
- ex_rd=0, id_rs=0 with a load in EX -> no stall.
- rst_n pulsed low during RPEND -> state=0 and redirect=0 immediately.
- With HAZARD_CTRL_PERF_EN, both counters read 0 after reset.
